uart_cmd_rx: RTL and testbench
==============================

// Module: uart_cmd_rx
// PURPOSE
//  Serial front end of the maze-runner command path. Receives 8N1 UART bytes on RX and
//  packs two consecutive bytes (high first) into a 16-bit route command. Presents the
//  command with a cmd_rdy/clr_cmd_rdy handshake to the command processor, which consumes
//  cmd two bits at a time.
// PARAMETERS
//  BAUD_DIV      2604  clk cycles per bit (50 MHz / 19200 baud); must be >= 8
//  TIMEOUT_BITS  40    bit periods allowed between high and low byte (RX_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  RX           in   1   asynchronous serial input, idle high
//  clr_cmd_rdy  in   1   consumer strobe; clears cmd_rdy
//  cmd          out  16  assembled command {byte0, byte1}
//  cmd_rdy      out  1   cmd valid, held until cleared
//  ovr_err      out  1   1-cycle pulse: new cmd completed while cmd_rdy was still high
//  frm_err      out  1   1-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset: cmd=16'h0000, cmd_rdy=0, ovr_err=0, frm_err=0, both FSMs idle, RX sync flops =1.
//  - RX passes through a 2-flop synchronizer, reset high; all logic uses the synced value.
//  - Byte FSM (sub-module) states: IDLE, START, DATA, STOP.
//    IDLE: synced RX falling edge -> START; baud counter loaded with BAUD_DIV/2.
//    START: at count expiry, RX sampled; if 1 (glitch) -> IDLE, else counter = BAUD_DIV,
//    -> DATA. DATA: sample at each expiry, shift LSB first; after 8th bit -> STOP.
//    STOP: sample; 1 -> byte_vld pulse 1 cycle; 0 -> frm_err pulse, no byte_vld.
//    Either way -> IDLE. STOP ends mid-stop-bit, so back-to-back bytes are accepted.
//  - Assembly FSM states: HI, LO.
//    HI: byte_vld -> byte latched into hi_byte, -> LO.
//    LO: byte_vld -> cmd <= {hi_byte, byte}, cmd_rdy <= 1, -> HI.
//    A framing error in LO returns the FSM to HI and drops the held byte.
//  - cmd is stable while cmd_rdy=1 unless overwritten by a newer command.
//  - Latency: cmd_rdy rises 1 clk after byte_vld of the low byte, about 19.5 bit times
//    after the first start edge.
//  - clr_cmd_rdy clears cmd_rdy next cycle. If clr_cmd_rdy coincides with completion of a
//    new cmd, the set wins: cmd_rdy stays 1 with the new cmd and ovr_err=0.
//  - Completion with cmd_rdy=1 and no clr: cmd is overwritten, cmd_rdy stays 1, ovr_err
//    pulses.
//  - RX held low (break): one frm_err, then the FSM waits in IDLE for RX high, with no
//    repeated errors.
//  - Baud counter width is $clog2(BAUD_DIV+1) bits and counts down to 0; no wrap.
// CONFIGURATION
//  RX_TIMEOUT_EN defined: in LO, a counter of TIMEOUT_BITS*BAUD_DIV clks runs while the
//    byte FSM is IDLE. At expiry the FSM returns to HI and discards hi_byte. The counter
//    is cleared on entry to LO and on every start edge.
//  RX_TIMEOUT_EN undefined: LO waits indefinitely and the counter is not built.
// STRUCTURE
//  Package uart_cmd_pkg: rx_state_t {IDLE,START,DATA,STOP}, asm_state_t {HI,LO},
//    localparam BAUD_DIV_SIM = 16.
//  Sub-module uart_rx_byte: synchronizer, baud counter, byte FSM, shift register.
//    Outputs rx_byte[7:0], byte_vld, frm_err, rx_busy.
//  Top: assembly FSM, cmd/cmd_rdy registers, ovr_err, optional timeout.
// TESTING  (BAUD_DIV=16, TIMEOUT_BITS=40)
//  1. Send 0xA5 then 0x3C -> cmd=16'hA53C, cmd_rdy=1 until clr_cmd_rdy, then 0 next clk.
//  2. Send 0x12,0x34 with no clr, then 0x56,0x78 -> cmd=16'h5678, one ovr_err pulse.
//  3. Send 0xFF with stop bit=0, then 0x00,0x0F -> one frm_err, cmd=16'h000F.
//  4. Assert clr_cmd_rdy on the same cycle the 2nd cmd completes -> cmd_rdy=1, ovr_err=0.
//  5. RX low pulse of 4 clks -> glitch rejected: no byte_vld, no frm_err.
//  6. RX_TIMEOUT_EN: send 0xAB, idle 41 bit times, send 0xCD,0xEF -> cmd=16'hCDEF.
//     Without the macro the same stimulus gives cmd=16'hABCD.
//  Reset asserted mid-byte in every scenario -> all outputs at reset values, next frame
//  decoded correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command receiver.
package uart_cmd_pkg;

  // Byte-level receiver states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Command assembly states: waiting for the high byte or the low byte
  typedef enum logic {
    HI,
    LO
  } asm_state_t;

  // Short bit period used when simulating the receiver
  localparam int BAUD_DIV_SIM = 16;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command handshake between the UART command receiver and the command processor.
interface uart_cmd_rx_if;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        ovr_err;
  logic        frm_err;

  // Receiver side: produces commands and error pulses
  modport master (
    output cmd,
    output cmd_rdy,
    output ovr_err,
    output frm_err,
    input  clr_cmd_rdy
  );

  // Consumer side: reads commands and acknowledges them
  modport slave (
    input  cmd,
    input  cmd_rdy,
    input  ovr_err,
    input  frm_err,
    output clr_cmd_rdy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: RX synchronizer, down-counting baud timer, byte FSM and
// LSB-first shift register. Emits a 1-cycle byte_vld or frm_err per frame.
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frm_err,
  output logic       rx_busy
);

  localparam int            CW       = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    rx_sync_reg;
  logic          rx_prev_reg;
  logic          rx_s;
  logic          start_edge;
  logic          baud_tick;
  rx_state_t     state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          byte_vld_reg;
  logic          frm_err_reg;

  assign rx_s       = rx_sync_reg[1];
  assign start_edge = rx_prev_reg & ~rx_s;
  // The sample point is the cycle the counter steps from 1 to 0, so a load
  // of N places the next sample exactly N clocks later.
  assign baud_tick  = (baud_cnt_reg == CNT_ONE);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_reg <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], RX};
      rx_prev_reg <= rx_s;
    end
  end

  // Byte FSM with baud counter, bit counter, shifter and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      byte_vld_reg <= 1'b0;
      frm_err_reg  <= 1'b0;
    end else begin
      byte_vld_reg <= 1'b0;
      frm_err_reg  <= 1'b0;
      if (baud_cnt_reg != '0) begin
        baud_cnt_reg <= baud_cnt_reg - CNT_ONE;
      end
      case (state_reg)
        IDLE: begin
          // A held-low line produces no edge, so a break reports only once
          if (start_edge) begin
            baud_cnt_reg <= HALF_BIT;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              baud_cnt_reg <= FULL_BIT;
              bit_cnt_reg  <= '0;
              state_reg    <= DATA;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg    <= {rx_s, shift_reg[7:1]};
            baud_cnt_reg <= FULL_BIT;
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end
        end
        STOP: begin
          // Leave mid-stop-bit so a directly following start bit is caught
          if (baud_tick) begin
            if (rx_s) begin
              byte_vld_reg <= 1'b1;
            end else begin
              frm_err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_byte  = shift_reg;
  assign byte_vld = byte_vld_reg;
  assign frm_err  = frm_err_reg;
  assign rx_busy  = (state_reg != IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver top: pairs received bytes (high first) into a 16-bit
// route command with a cmd_rdy / clr_cmd_rdy handshake and overrun detection.
// Optional feature macro RX_TIMEOUT_EN: abandons a held high byte when the
// line stays idle for TIMEOUT_BITS bit periods.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
`ifdef RX_TIMEOUT_EN
  , parameter int TIMEOUT_BITS = 40
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  uart_cmd_rx_if.master cmd_if
);

  logic [7:0]  rx_byte;
  logic        byte_vld;
  logic        frm_err;
  logic        rx_busy;
  logic        timeout_hit;
  logic        cmd_done;
  asm_state_t  asm_state_reg;
  logic [7:0]  hi_byte_reg;
  logic [15:0] cmd_reg;
  logic        cmd_rdy_reg;
  logic        ovr_err_reg;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rx_byte  (rx_byte),
    .byte_vld (byte_vld),
    .frm_err  (frm_err),
    .rx_busy  (rx_busy)
  );

`ifdef RX_TIMEOUT_EN
  localparam int            TO_CYC  = TIMEOUT_BITS * BAUD_DIV;
  localparam int            TW      = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC);

  logic [TW-1:0] to_cnt_reg;

  // Idle time in LO; held at zero in HI (so it starts clean on entry to LO)
  // and while a frame is in progress (so each start edge restarts it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (asm_state_reg != LO || rx_busy) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_LAST) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  assign timeout_hit = (asm_state_reg == LO) && (to_cnt_reg == TO_LAST);
`else
  // Without the timeout the receiver-busy flag has no consumer
  logic unused_busy;
  assign unused_busy = rx_busy;
  assign timeout_hit = 1'b0;
`endif

  assign cmd_done = (asm_state_reg == LO) && byte_vld;

  // Assembly FSM plus command, ready and overrun registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state_reg <= HI;
      hi_byte_reg   <= '0;
      cmd_reg       <= '0;
      cmd_rdy_reg   <= 1'b0;
      ovr_err_reg   <= 1'b0;
    end else begin
      ovr_err_reg <= 1'b0;
      case (asm_state_reg)
        HI: begin
          if (byte_vld) begin
            hi_byte_reg   <= rx_byte;
            asm_state_reg <= LO;
          end
        end
        LO: begin
          if (byte_vld) begin
            cmd_reg       <= {hi_byte_reg, rx_byte};
            asm_state_reg <= HI;
          end else if (frm_err || timeout_hit) begin
            hi_byte_reg   <= '0;
            asm_state_reg <= HI;
          end
        end
        default: asm_state_reg <= HI;
      endcase
      // A completing command beats a simultaneous clear
      if (cmd_done) begin
        cmd_rdy_reg <= 1'b1;
        ovr_err_reg <= cmd_rdy_reg & ~cmd_if.clr_cmd_rdy;
      end else if (cmd_if.clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
      end
    end
  end

  assign cmd_if.cmd     = cmd_reg;
  assign cmd_if.cmd_rdy = cmd_rdy_reg;
  assign cmd_if.ovr_err = ovr_err_reg;
  assign cmd_if.frm_err = frm_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios plus random frames, checked against
// a frame-level model of command assembly, ready, overrun and framing errors.
`timescale 1ns/1ps
module tb_uart_cmd_rx;
  import uart_cmd_pkg::*;

  localparam int BD = BAUD_DIV_SIM;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic RX    = 1'b1;

  uart_cmd_rx_if cif();

  uart_cmd_rx #(
    .BAUD_DIV (BD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .cmd_if (cif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: what the outputs must be once a frame has fully ended
  logic [15:0] m_cmd     = 16'h0000;
  logic        m_rdy     = 1'b0;
  bit          m_have_hi = 1'b0;
  logic [7:0]  m_hi      = 8'h00;
  int          m_ovr     = 0;
  int          m_frm     = 0;
  int          obs_ovr   = 0;
  int          obs_frm   = 0;
  bit          settled   = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Effect of one complete received frame on the command path
  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input bit clr_coinc);
    if (!stop_ok) begin
      m_frm++;
      m_have_hi = 1'b0;
    end else if (!m_have_hi) begin
      m_hi      = b;
      m_have_hi = 1'b1;
    end else begin
      if (m_rdy && !clr_coinc) m_ovr++;
      m_cmd     = {m_hi, b};
      m_rdy     = 1'b1;
      m_have_hi = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_cmd     = 16'h0000;
    m_rdy     = 1'b0;
    m_have_hi = 1'b0;
    m_hi      = 8'h00;
  endtask

  // Single compare process: counts error pulses, and between frames checks
  // every cycle that the DUT matches the model
  always @(posedge clk) begin
    #2;
    if (cif.ovr_err === 1'b1) obs_ovr++;
    if (cif.frm_err === 1'b1) obs_frm++;
    if (settled) begin
      chk("cmd", {16'h0, cif.cmd}, {16'h0, m_cmd});
      chk("cmd_rdy", {31'h0, cif.cmd_rdy}, {31'h0, m_rdy});
      chk("ovr_cnt", obs_ovr, m_ovr);
      chk("frm_cnt", obs_frm, m_frm);
    end
  end

  // Drive one 8N1 frame; abort_at < 10 stops after that many bit periods
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_at);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(negedge clk);
    settled = 1'b0;
    $display("tx byte=%02h stop=%0d abort_at=%0d", b, stop_ok, abort_at);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_at) break;
      RX = bits[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok);
    send_frame(b, stop_ok, 10);
    model_byte(b, stop_ok, 1'b0);
    settled = 1'b1;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    cif.clr_cmd_rdy = 1'b1;
    m_rdy = 1'b0;
    @(negedge clk);
    cif.clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cut a frame off mid-byte with an asynchronous reset
  task automatic reset_mid_byte(input logic [7:0] b, input int abort_at);
    send_frame(b, 1'b1, abort_at);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cmd", {16'h0, cif.cmd}, 32'h0);
    chk("rst_rdy", {31'h0, cif.cmd_rdy}, 32'h0);
    chk("rst_ovr", {31'h0, cif.ovr_err}, 32'h0);
    chk("rst_frm", {31'h0, cif.frm_err}, 32'h0);
    settled = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0;
    int frm0;
    bit seen;
    cif.clr_cmd_rdy = 1'b0;
    idle_cycles(4);
    chk("reset_cmd", {16'h0, cif.cmd}, 32'h0);
    chk("reset_rdy", {31'h0, cif.cmd_rdy}, 32'h0);
    chk("reset_ovr", {31'h0, cif.ovr_err}, 32'h0);
    chk("reset_frm", {31'h0, cif.frm_err}, 32'h0);
    rst_n = 1'b1;
    idle_cycles(3);

    // 1: basic command, then clear
    frame(8'hA5, 1'b1);
    frame(8'h3C, 1'b1);
    chk("s1_model", {16'h0, m_cmd}, 32'hA53C);
    chk("s1_cmd", {16'h0, cif.cmd}, 32'hA53C);
    chk("s1_rdy", {31'h0, cif.cmd_rdy}, 32'h1);
    idle_cycles(5);
    chk("s1_rdy_held", {31'h0, cif.cmd_rdy}, 32'h1);
    clr_pulse();
    chk("s1_rdy_clr", {31'h0, cif.cmd_rdy}, 32'h0);
    reset_mid_byte(8'h5A, 4);

    // 2: overrun
    ovr0 = obs_ovr;
    frame(8'h12, 1'b1);
    frame(8'h34, 1'b1);
    frame(8'h56, 1'b1);
    frame(8'h78, 1'b1);
    chk("s2_model", {16'h0, m_cmd}, 32'h5678);
    chk("s2_cmd", {16'h0, cif.cmd}, 32'h5678);
    chk("s2_ovr_pulses", obs_ovr - ovr0, 1);
    reset_mid_byte(8'hC3, 6);

    // 3: framing error discards the byte
    frm0 = obs_frm;
    frame(8'hFF, 1'b0);
    frame(8'h00, 1'b1);
    frame(8'h0F, 1'b1);
    chk("s3_model", {16'h0, m_cmd}, 32'h000F);
    chk("s3_cmd", {16'h0, cif.cmd}, 32'h000F);
    chk("s3_frm_pulses", obs_frm - frm0, 1);
    reset_mid_byte(8'h81, 3);

    // 4: clear coinciding with completion of a second command
    frame(8'h11, 1'b1);
    frame(8'h22, 1'b1);
    frame(8'h33, 1'b1);
    ovr0 = obs_ovr;
    seen = 1'b0;
    fork
      send_frame(8'h44, 1'b1, 10);
      begin
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          if (dut.u_byte.byte_vld === 1'b1) begin
            cif.clr_cmd_rdy = 1'b1;
            seen = 1'b1;
            @(negedge clk);
            cif.clr_cmd_rdy = 1'b0;
          end
        end
      end
    join
    chk("s4_vld_seen", {31'h0, seen}, 32'h1);
    model_byte(8'h44, 1'b1, 1'b1);
    settled = 1'b1;
    chk("s4_cmd", {16'h0, cif.cmd}, 32'h3344);
    chk("s4_rdy", {31'h0, cif.cmd_rdy}, 32'h1);
    chk("s4_no_ovr", obs_ovr - ovr0, 0);
    reset_mid_byte(8'h7E, 5);

    // 5: 4-clock glitch between high and low byte is ignored
    frm0 = obs_frm;
    frame(8'h9A, 1'b1);
    @(negedge clk);
    RX = 1'b0;
    idle_cycles(4);
    RX = 1'b1;
    idle_cycles(3 * BD);
    frame(8'hBC, 1'b1);
    chk("s5_cmd", {16'h0, cif.cmd}, 32'h9ABC);
    chk("s5_no_frm", obs_frm - frm0, 0);

    // Break: line low for 40 bit times gives exactly one framing error
    frm0 = obs_frm;
    frame(8'h01, 1'b1);
    @(negedge clk);
    settled = 1'b0;
    RX = 1'b0;
    idle_cycles(30 * BD);
    m_frm++;
    m_have_hi = 1'b0;
    settled = 1'b1;
    idle_cycles(10 * BD);
    RX = 1'b1;
    idle_cycles(2 * BD);
    chk("brk_frm_pulses", obs_frm - frm0, 1);
    frame(8'hDE, 1'b1);
    frame(8'hAD, 1'b1);
    chk("brk_cmd", {16'h0, cif.cmd}, 32'hDEAD);
    reset_mid_byte(8'h24, 7);

    // 6: long idle between high and low byte
    frame(8'hAB, 1'b1);
    idle_cycles(41 * BD);
`ifdef RX_TIMEOUT_EN
    m_have_hi = 1'b0;
`endif
    frame(8'hCD, 1'b1);
    frame(8'hEF, 1'b1);
`ifdef RX_TIMEOUT_EN
    chk("s6_cmd", {16'h0, cif.cmd}, 32'hCDEF);
`else
    chk("s6_cmd", {16'h0, cif.cmd}, 32'hABCD);
`endif
    reset_mid_byte(8'h66, 2);

    // Random frames with occasional bad stop bits, clears and gaps
    for (int n = 0; n < 40; n++) begin
      logic [7:0] rb;
      bit ok;
      rb = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      frame(rb, ok);
      if ($urandom_range(0, 2) == 0) clr_pulse();
      idle_cycles($urandom_range(0, 2 * BD));
    end
    reset_mid_byte(8'($urandom_range(0, 255)), 1 + $urandom_range(0, 7));
    frame(8'hBE, 1'b1);
    frame(8'hEF, 1'b1);
    chk("final_cmd", {16'h0, cif.cmd}, 32'hBEEF);
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
